// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the block-granular data memory.
//   BLOCK_W          width of one cache block in bits
//   ADDR_W           width of the block index bus
//   CNT_W            width of the latency counter (enough for LATENCY < 64)
//   DEFAULT_LATENCY  access latency used when the instantiator gives none
//   state_t          controller states
//   idx_width()      index bits needed to address a given number of blocks
package dmem_pkg;

  localparam int BLOCK_W         = 128;
  localparam int ADDR_W          = 16;
  localparam int CNT_W           = 6;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // A single-block memory still needs one index bit to keep the port legal.
  function automatic int idx_width(input int num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the cache controller and dmem.
//   ren, wen       level read / write requests from the controller
//   block_address  block index (upper bits beyond the array size are ignored)
//   din            write data
//   ready          memory idle and able to accept a request
//   done           access complete, held until both requests drop
//   dout           read data
// modport master is the cache controller side, slave is the memory side.
interface dmem_if;
  import dmem_pkg::*;

  logic               ren;
  logic               wen;
  logic [ADDR_W-1:0]  block_address;
  logic [BLOCK_W-1:0] din;
  logic               ready;
  logic               done;
  logic [BLOCK_W-1:0] dout;

  modport master (
    output ren, wen, block_address, din,
    input  ready, done, dout
  );

  modport slave (
    input  ren, wen, block_address, din,
    output ready, done, dout
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port storage of NUM_BLOCKS x BLOCK_W bits.
//   clock   rising-edge clock
//   we      write enable: wdata is stored at index on the edge
//   re      read enable: rdata is loaded from index on the edge
//   index   block index
//   wdata   write data
//   rdata   registered read data, holds between reads
// There is no reset: contents survive reset and power up with block i = i.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int NUM_BLOCKS = 256,
  parameter int IDX_W      = 8
) (
  input  logic               clock,
  input  logic               we,
  input  logic               re,
  input  logic [IDX_W-1:0]   index,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  typedef logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] mem_t;

  // Power-up image: every block holds its own index, zero-extended.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      m[i] = BLOCK_W'(unsigned'(i));
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  // The controller never raises we and re together, so one port is enough.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[index] <= wdata;
    end
    if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dmem.sv
// dmem: main-memory model behind the L1 data cache. Each access moves one
// 128-bit block and completes a fixed LATENCY cycles after acceptance.
//   clock  rising-edge clock
//   reset  asynchronous active-low reset (control state only, not storage)
//   bus    dmem_if slave: ren/wen/block_address/din in, ready/done/dout out
// Parameters: NUM_BLOCKS (power of two), LATENCY (1..63).
module dmem
  import dmem_pkg::*;
#(
  parameter int NUM_BLOCKS = 256,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic   clock,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_BLOCKS);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  logic [1:0]         rst_sync;
  logic               rst_n;
  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               finish;
  logic               op_write;
  logic [IDX_W-1:0]   addr_q;
  logic [BLOCK_W-1:0] din_q;
  logic               has_data;
  logic [BLOCK_W-1:0] rdata;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.block_address[ADDR_W-1:IDX_W];

  // Reset asserts immediately but releases two edges later, so the first
  // edge the control logic sees after release is free of recovery hazards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ready/done are gated by the internal reset so both read 0 the moment
  // reset is asserted, even though the state register already shows IDLE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    bus.ready  = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = rst_n;
        if (bus.ren || bus.wen) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (count == LAT_CNT) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        bus.done = rst_n;
        if (!bus.ren && !bus.wen) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The counter starts at 1 on the acceptance edge, so it equals LATENCY
  // just before the LATENCY-th edge after acceptance, which enters DONE.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= CNT_W'(1);
    end else if (finish) begin
      count <= '0;
    end else if (state == BUSY) begin
      count <= count + CNT_W'(1);
    end
  end

  // Request capture: write wins when both requests are high, and nothing on
  // the bus is looked at again until the next acceptance.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      op_write <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else if (accept) begin
      op_write <= bus.wen;
      addr_q   <= bus.block_address[IDX_W-1:0];
      din_q    <= bus.din;
    end
  end

  // The array's read register has no reset, so dout is masked until a read
  // has completed since the last reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      has_data <= 1'b0;
    end else if (finish && !op_write) begin
      has_data <= 1'b1;
    end
  end

  dmem_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (finish && op_write),
    .re    (finish && !op_write),
    .index (addr_q),
    .wdata (din_q),
    .rdata (rdata)
  );

  assign bus.dout = has_data ? rdata : '0;

endmodule

// File: tb/tb_dmem.sv
// tb_dmem: self-checking bench for dmem. Table-driven accesses with a queue
// scoreboard for read data, plus hand-written sequences for held requests
// and mid-access reset.
module tb_dmem;
  import dmem_pkg::*;

  localparam int LAT = 10;

  typedef struct {
    logic         r;
    logic         w;
    logic [15:0]  addr;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  logic clock;
  logic reset;
  bit   toggling;

  int checks;
  int errors;

  logic [127:0] exp_q[$];
  logic [127:0] last_read;
  vec_t         vecs[$];

  dmem_if bus ();

  dmem #(
    .NUM_BLOCKS (256),
    .LATENCY    (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One complete access: drive, wait for done, compare, release.
  task automatic apply_stimulus(input vec_t v);
    int cyc;
    logic [127:0] exp;
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_output("ready_before_access", 128'(bus.ready), 128'(1));
    @(negedge clock);
    bus.ren           = v.r;
    bus.wen           = v.w;
    bus.block_address = v.addr;
    bus.din           = v.din;
    if (v.r && !v.w) exp_q.push_back(v.exp);
    @(posedge clock);
    #1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_output("latency", 128'(cyc), 128'(LAT));
    check_output("ready_low_in_done", 128'(bus.ready), 128'(0));
    if (v.r && !v.w) begin
      if (exp_q.size() == 0) begin
        check_output("scoreboard_empty", 128'(1), 128'(0));
      end else begin
        exp = exp_q.pop_front();
        check_output("read_data", bus.dout, exp);
        last_read = exp;
      end
    end else begin
      check_output("dout_held_on_write", bus.dout, last_read);
    end
    @(negedge clock);
    bus.ren = 1'b0;
    bus.wen = 1'b0;
    @(posedge clock);
    #1;
    check_output("done_release", 128'(bus.done), 128'(0));
    check_output("ready_release", 128'(bus.ready), 128'(1));
  endtask

  task automatic run_vectors();
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic add_vec(input logic r, input logic w, input logic [15:0] a,
                         input logic [127:0] d, input logic [127:0] e);
    vec_t v;
    v.r = r; v.w = w; v.addr = a; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // Start an access, then assert reset three cycles into it.
  task automatic mid_reset(input logic w, input logic [127:0] d);
    @(negedge clock);
    bus.ren           = ~w;
    bus.wen           = w;
    bus.block_address = 16'd4;
    bus.din           = d;
    @(posedge clock);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_output("reset_ready", 128'(bus.ready), 128'(0));
    check_output("reset_done", 128'(bus.done), 128'(0));
    check_output("reset_dout", bus.dout, 128'(0));
    @(negedge clock);
    bus.ren = 1'b0;
    bus.wen = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_output("ready_after_reset", 128'(bus.ready), 128'(1));
    last_read = '0;
    add_vec(1'b1, 1'b0, 16'd4, '0, 128'd4);
    run_vectors();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    checks            = 0;
    errors            = 0;
    last_read         = '0;
    toggling          = 1'b0;
    reset             = 1'b0;
    bus.ren           = 1'b0;
    bus.wen           = 1'b0;
    bus.block_address = '0;
    bus.din           = '0;

    // Reset state
    #12;
    check_output("reset_ready_init", 128'(bus.ready), 128'(0));
    check_output("reset_done_init", 128'(bus.done), 128'(0));
    check_output("reset_dout_init", bus.dout, 128'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_output("ready_init", 128'(bus.ready), 128'(1));

    // Held ren with a toggling address: one access, done held until release
    @(negedge clock);
    bus.ren           = 1'b1;
    bus.block_address = 16'd0;
    @(posedge clock);
    #2;
    toggling = 1'b1;
    fork
      begin
        while (toggling) begin
          bus.block_address = bus.block_address ^ 16'h0003;
          #5;
        end
      end
    join_none
    #1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_output("held_latency", 128'(cyc), 128'(LAT));
    check_output("held_dout", bus.dout, 128'(0));
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      check_output("held_done", 128'(bus.done), 128'(1));
      check_output("held_ready", 128'(bus.ready), 128'(0));
      check_output("held_dout_stable", bus.dout, 128'(0));
    end
    @(negedge clock);
    toggling = 1'b0;
    bus.ren  = 1'b0;
    @(posedge clock);
    #1;
    check_output("held_release_done", 128'(bus.done), 128'(0));
    check_output("held_release_ready", 128'(bus.ready), 128'(1));
    #10;
    bus.block_address = '0;
    last_read = '0;

    // Power-up read sweep
    for (int k = 0; k < 32; k++) begin
      add_vec(1'b1, 1'b0, 16'(k), '0, 128'(k));
    end
    run_vectors();

    // Mid-access reset: read, then write of 0xAA that must not commit
    mid_reset(1'b0, '0);
    mid_reset(1'b1, 128'hAA);

    // Simultaneous ren/wen (write wins) and address aliasing
    add_vec(1'b1, 1'b1, 16'd7, 128'h55, '0);
    add_vec(1'b1, 1'b0, 16'd7, '0, 128'h55);
    add_vec(1'b0, 1'b1, 16'h0105, 128'h99, '0);
    add_vec(1'b1, 1'b0, 16'h0005, '0, 128'h99);
    run_vectors();

    // Write k+1 to address k, then read everything back
    for (int k = 0; k < 32; k++) begin
      add_vec(1'b0, 1'b1, 16'(k), 128'(k + 1), '0);
    end
    for (int k = 0; k < 32; k++) begin
      add_vec(1'b1, 1'b0, 16'(k), '0, 128'(k + 1));
    end
    run_vectors();

    check_output("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
